router_fsm: RTL and testbench

Control state machine for the 1x3 packet router. It sits directly upstream of the byte register stage and drives that stage's phase strobes: `detect_add`, `lfd_state`, `ld_state`, `laf_state`, `full_state` and `rst_int_reg`. It also generates `write_enb_reg` toward the output FIFOs and `busy` toward the source. It takes back `parity_done` and `low_packet_valid` from the register stage.

---
 rtl/router_pkg.sv | 33 +++
 rtl/router_fsm.sv | 121 ++++++++++++
 tb/tb_router_fsm.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/router_pkg.sv
`default_nettype none
// ============================================================================
// Module      : router_pkg
// Description : Shared constants and state type for the 1x3 router control FSM.
// Revision    : 1.0 - initial release
// ============================================================================
package router_pkg;

   localparam int         NUM_PORTS    = 3;
   localparam logic [1:0] ADDR_INVALID = 2'b11;

   localparam logic [2:0] S_DECODE_ADDRESS     = 3'd0;
   localparam logic [2:0] S_WAIT_TILL_EMPTY    = 3'd1;
   localparam logic [2:0] S_LOAD_FIRST_DATA    = 3'd2;
   localparam logic [2:0] S_LOAD_DATA          = 3'd3;
   localparam logic [2:0] S_FIFO_FULL_STATE    = 3'd4;
   localparam logic [2:0] S_LOAD_AFTER_FULL    = 3'd5;
   localparam logic [2:0] S_LOAD_PARITY        = 3'd6;
   localparam logic [2:0] S_CHECK_PARITY_ERROR = 3'd7;

   typedef enum logic [2:0] {
      DECODE_ADDRESS     = S_DECODE_ADDRESS,
      WAIT_TILL_EMPTY    = S_WAIT_TILL_EMPTY,
      LOAD_FIRST_DATA    = S_LOAD_FIRST_DATA,
      LOAD_DATA          = S_LOAD_DATA,
      FIFO_FULL_STATE    = S_FIFO_FULL_STATE,
      LOAD_AFTER_FULL    = S_LOAD_AFTER_FULL,
      LOAD_PARITY        = S_LOAD_PARITY,
      CHECK_PARITY_ERROR = S_CHECK_PARITY_ERROR
   } state_t;

endpackage : router_pkg
`default_nettype wire

// File: rtl/router_fsm.sv
`default_nettype none
// ============================================================================
// Module      : router_fsm
// Description : Control FSM of the 1x3 packet router; drives the register-stage
//               phase strobes, FIFO write enable and source busy.
// Revision    : 1.0 - initial release
// ============================================================================
module router_fsm
   import router_pkg::*;
(
   input  logic       clock,
   input  logic       resetn,
   input  logic       pkt_valid,
   input  logic [1:0] data_in,
   input  logic       fifo_full,
   input  logic       fifo_empty_0,
   input  logic       fifo_empty_1,
   input  logic       fifo_empty_2,
   input  logic       soft_reset_0,
   input  logic       soft_reset_1,
   input  logic       soft_reset_2,
   input  logic       parity_done,
   input  logic       low_packet_valid,
   output logic       detect_add,
   output logic       lfd_state,
   output logic       ld_state,
   output logic       laf_state,
   output logic       full_state,
   output logic       rst_int_reg,
   output logic       write_enb_reg,
   output logic       busy
);

   state_t     r_state;
   state_t     w_next_state;
   logic [1:0] r_addr;

   // Index 3 (the invalid address) is padded low so it never selects a port.
   logic [3:0] w_fifo_empty;
   logic [3:0] w_soft_reset;
   logic       w_addr_valid;

   assign w_fifo_empty = {1'b0, fifo_empty_2, fifo_empty_1, fifo_empty_0};
   assign w_soft_reset = {1'b0, soft_reset_2, soft_reset_1, soft_reset_0};
   assign w_addr_valid = pkt_valid && (data_in != ADDR_INVALID);

   always_ff @(posedge clock) begin
      if (!resetn) begin
         r_state <= DECODE_ADDRESS;
         r_addr  <= 2'b00;
      end else begin
         r_state <= w_next_state;
         if ((r_state == DECODE_ADDRESS) && w_addr_valid) begin
            r_addr <= data_in;
         end
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         DECODE_ADDRESS: begin
            if (w_addr_valid) begin
               w_next_state = w_fifo_empty[data_in] ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
            end
         end
         WAIT_TILL_EMPTY: begin
            if (w_fifo_empty[r_addr]) begin
               w_next_state = LOAD_FIRST_DATA;
            end
         end
         LOAD_FIRST_DATA: w_next_state = LOAD_DATA;
         LOAD_DATA: begin
            // Full takes priority so a simultaneous end-of-packet finishes via LAF.
            if (fifo_full) begin
               w_next_state = FIFO_FULL_STATE;
            end else if (!pkt_valid) begin
               w_next_state = LOAD_PARITY;
            end
         end
         FIFO_FULL_STATE: begin
            if (!fifo_full) begin
               w_next_state = LOAD_AFTER_FULL;
            end
         end
         LOAD_AFTER_FULL: begin
            if (parity_done) begin
               w_next_state = DECODE_ADDRESS;
            end else if (low_packet_valid) begin
               w_next_state = LOAD_PARITY;
            end else begin
               w_next_state = LOAD_DATA;
            end
         end
         LOAD_PARITY: w_next_state = CHECK_PARITY_ERROR;
         CHECK_PARITY_ERROR: begin
            w_next_state = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
         end
         default: w_next_state = DECODE_ADDRESS;
      endcase

      // A flush of the selected port abandons the packet from any active state.
      if ((r_state != DECODE_ADDRESS) && w_soft_reset[r_addr]) begin
         w_next_state = DECODE_ADDRESS;
      end
   end

   always_comb begin
      detect_add    = (r_state == DECODE_ADDRESS);
      lfd_state     = (r_state == LOAD_FIRST_DATA);
      ld_state      = (r_state == LOAD_DATA);
      laf_state     = (r_state == LOAD_AFTER_FULL);
      full_state    = (r_state == FIFO_FULL_STATE);
      rst_int_reg   = (r_state == CHECK_PARITY_ERROR);
      write_enb_reg = (r_state == LOAD_DATA) || (r_state == LOAD_PARITY) ||
                      (r_state == LOAD_AFTER_FULL);
      busy          = (r_state != DECODE_ADDRESS) && (r_state != LOAD_DATA);
   end

endmodule : router_fsm
`default_nettype wire

// File: tb/tb_router_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_router_fsm
// Description : Scoreboard bench for router_fsm using directed packet scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_router_fsm;

   // Output vector: {detect_add, lfd, ld, laf, full, rst_int, write_enb, busy}
   localparam logic [7:0] E_DEC  = 8'b1000_0000;
   localparam logic [7:0] E_WAIT = 8'b0000_0001;
   localparam logic [7:0] E_LFD  = 8'b0100_0001;
   localparam logic [7:0] E_LD   = 8'b0010_0010;
   localparam logic [7:0] E_FULL = 8'b0000_1001;
   localparam logic [7:0] E_LAF  = 8'b0001_0011;
   localparam logic [7:0] E_LP   = 8'b0000_0011;
   localparam logic [7:0] E_CPE  = 8'b0000_0101;

   typedef struct {
      logic [7:0] exp;
      string      tag;
   } exp_t;

   logic       clock = 1'b0;
   logic       resetn;
   logic       pkt_valid;
   logic [1:0] data_in;
   logic       fifo_full;
   logic [2:0] fifo_empty;
   logic [2:0] soft_reset;
   logic       parity_done;
   logic       low_packet_valid;
   logic       detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg;
   logic       write_enb_reg, busy;

   exp_t       sb_q[$];
   int         checks = 0;
   int         errors = 0;

   always #5 clock = ~clock;

   router_fsm dut (
      .clock            (clock),
      .resetn           (resetn),
      .pkt_valid        (pkt_valid),
      .data_in          (data_in),
      .fifo_full        (fifo_full),
      .fifo_empty_0     (fifo_empty[0]),
      .fifo_empty_1     (fifo_empty[1]),
      .fifo_empty_2     (fifo_empty[2]),
      .soft_reset_0     (soft_reset[0]),
      .soft_reset_1     (soft_reset[1]),
      .soft_reset_2     (soft_reset[2]),
      .parity_done      (parity_done),
      .low_packet_valid (low_packet_valid),
      .detect_add       (detect_add),
      .lfd_state        (lfd_state),
      .ld_state         (ld_state),
      .laf_state        (laf_state),
      .full_state       (full_state),
      .rst_int_reg      (rst_int_reg),
      .write_enb_reg    (write_enb_reg),
      .busy             (busy)
   );

   // Monitor: after every rising edge, compare the outputs against the oldest expectation.
   always @(posedge clock) begin
      logic [7:0] got;
      exp_t       e;
      #1;
      if (sb_q.size() > 0) begin
         e   = sb_q.pop_front();
         got = {detect_add, lfd_state, ld_state, laf_state, full_state,
                rst_int_reg, write_enb_reg, busy};
         checks++;
         if (got !== e.exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", e.tag, got, e.exp);
         end
      end
   end

   task automatic set_in(input logic pv, input logic [1:0] din, input logic ff,
                         input logic [2:0] fe, input logic [2:0] sr,
                         input logic pd, input logic lpv);
      pkt_valid        = pv;
      data_in          = din;
      fifo_full        = ff;
      fifo_empty       = fe;
      soft_reset       = sr;
      parity_done      = pd;
      low_packet_valid = lpv;
   endtask

   // Current inputs are sampled at the next edge; the expected outputs after that edge are queued.
   task automatic cyc(input string tag, input logic [7:0] exp);
      exp_t e;
      e.exp = exp;
      e.tag = tag;
      sb_q.push_back(e);
      @(negedge clock);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      resetn = 1'b0;
      set_in(1'b0, 2'b00, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0);
      cyc("reset", E_DEC);
      cyc("reset_hold", E_DEC);
      resetn = 1'b1;

      // Clean packet to port 1
      set_in(1'b1, 2'b01, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0);
      cyc("clean_lfd", E_LFD);
      cyc("clean_ld1", E_LD);
      cyc("clean_ld2", E_LD);
      cyc("clean_ld3", E_LD);
      pkt_valid = 1'b0;
      cyc("clean_lp", E_LP);
      cyc("clean_cpe", E_CPE);
      cyc("clean_dec", E_DEC);

      // Busy destination port 2; other ports' empty flags must not release it
      set_in(1'b1, 2'b10, 1'b0, 3'b011, 3'b000, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) cyc("wait_hold", E_WAIT);
      fifo_empty = 3'b111;
      cyc("wait_lfd", E_LFD);
      cyc("wait_ld", E_LD);
      pkt_valid = 1'b0;
      cyc("wait_lp", E_LP);
      cyc("wait_cpe", E_CPE);
      cyc("wait_dec", E_DEC);

      // Full stall on the second LD cycle, port 0
      set_in(1'b1, 2'b00, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0);
      cyc("stall_lfd", E_LFD);
      cyc("stall_ld1", E_LD);
      cyc("stall_ld2", E_LD);
      fifo_full = 1'b1;
      for (int i = 0; i < 4; i++) cyc("stall_full", E_FULL);
      fifo_full = 1'b0;
      cyc("stall_laf", E_LAF);
      cyc("stall_back_ld", E_LD);
      pkt_valid = 1'b0;
      cyc("stall_lp", E_LP);
      cyc("stall_cpe", E_CPE);
      cyc("stall_dec", E_DEC);

      // Full while checking parity
      set_in(1'b1, 2'b01, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0);
      cyc("fpar_lfd", E_LFD);
      cyc("fpar_ld", E_LD);
      pkt_valid = 1'b0;
      cyc("fpar_lp", E_LP);
      cyc("fpar_cpe", E_CPE);
      fifo_full = 1'b1;
      cyc("fpar_full", E_FULL);
      fifo_full = 1'b0;
      cyc("fpar_laf", E_LAF);
      parity_done = 1'b1;
      cyc("fpar_dec", E_DEC);
      parity_done = 1'b0;

      // Full and end-of-packet together: full wins, then LAF goes to parity
      set_in(1'b1, 2'b10, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0);
      cyc("both_lfd", E_LFD);
      cyc("both_ld", E_LD);
      pkt_valid = 1'b0;
      fifo_full = 1'b1;
      cyc("both_full", E_FULL);
      fifo_full = 1'b0;
      cyc("both_laf", E_LAF);
      low_packet_valid = 1'b1;
      cyc("both_lp", E_LP);
      low_packet_valid = 1'b0;
      cyc("both_cpe", E_CPE);
      cyc("both_dec", E_DEC);

      // Invalid address is dropped
      set_in(1'b1, 2'b11, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) cyc("invalid_dec", E_DEC);
      pkt_valid = 1'b0;
      cyc("idle_dec", E_DEC);

      // Soft reset: unselected port ignored, selected port aborts; ignored while decoding
      set_in(1'b1, 2'b01, 1'b0, 3'b111, 3'b010, 1'b0, 1'b0);
      cyc("sr_dec_ignored", E_LFD);
      soft_reset = 3'b000;
      cyc("sr_ld", E_LD);
      soft_reset = 3'b001;
      cyc("sr0_no_effect", E_LD);
      soft_reset = 3'b010;
      cyc("sr1_abort", E_DEC);
      set_in(1'b0, 2'b00, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0);
      cyc("sr_idle", E_DEC);

      // Reset mid-packet
      set_in(1'b1, 2'b00, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0);
      cyc("rst_lfd", E_LFD);
      cyc("rst_ld", E_LD);
      resetn = 1'b0;
      cyc("rst_mid", E_DEC);
      resetn    = 1'b1;
      pkt_valid = 1'b0;
      cyc("rst_after", E_DEC);

      @(negedge clock);
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending expected 0", sb_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_router_fsm
`default_nettype wire
